axi4_rd_arbiter: RTL

- Two-master AXI4 read-channel arbiter. It shares the core's single `io_master` read port (AR/R) between the instruction-cache refill path (m0) and the data-cache/MMIO path (m1).
- One read transaction is outstanding at a time. The block:
  - grants one master;
  - forwards its AR channel;
  - steers R beats back to that master until the `rlast` handshake;
  - checks burst length and ID consistency.
- It sits between the cache refill engines and the top-level `io_master_ar*`/`io_master_r*` pins. The write channels bypass it.

---
 rtl/axi4_rd_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi4_rd_arbiter.sv
// rtl/axi4_rd_arbiter.sv - two-master AXI4 read-channel arbiter, one transaction outstanding
//
// Shares one AXI4 read port (AR/R) between m0 (instruction refill) and m1
// (data cache / MMIO). One master is granted, its AR is forwarded, and R beats
// are steered back to it until the rlast handshake. Burst length and ID are checked.
//
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   m0_* / m1_*                   master AR (arvalid/arready/araddr/arlen/arsize)
//                                 and R (rvalid/rready/rdata/rresp/rlast)
//   s_ar*                         slave AR channel (arvalid/arready/araddr/arid/arlen/arsize/arburst)
//   s_r*                          slave R channel (rvalid/rready/rdata/rresp/rlast/rid)
//   proto_err                     sticky protocol-error flag
//
// Build option: AXI_RD_ARB_RR_EN selects round-robin arbitration.
// Without it, fixed priority applies and m1 wins.

module axi4_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [3:0]        s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic [3:0]        s_rid,
    output logic              proto_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic       grant, grant_nxt;
    logic       win;
    logic [7:0] exp_len;
    logic [7:0] beat_cnt;
    logic       err_q;
    logic       r_hs;
    logic       beat_err;

`ifdef AXI_RD_ARB_RR_EN
    logic last_grant;

    // Only a tie consults history; a lone requester always wins.
    assign win = (m0_arvalid & m1_arvalid) ? ~last_grant : m1_arvalid;
`else
    // Data side always beats instruction refill.
    assign win = m1_arvalid;
`endif

    // AR payload comes straight from the granted master, which holds it stable.
    assign s_araddr  = grant ? m1_araddr : m0_araddr;
    assign s_arlen   = grant ? m1_arlen  : m0_arlen;
    assign s_arsize  = grant ? m1_arsize : m0_arsize;
    assign s_arid    = {3'b000, grant};
    assign s_arburst = 2'b01;

    // R payload is broadcast. Only rvalid is steered.
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

    assign r_hs     = (state == DATA) & s_rvalid & s_rready;
    assign beat_err = (s_rid != s_arid) | (s_rlast != (beat_cnt == exp_len));

    // Current-beat error is OR'd in so the flag is visible on the offending beat itself.
    assign proto_err = err_q | (r_hs & beat_err);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (m0_arvalid | m1_arvalid) begin
                    grant_nxt = win;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_arvalid  = 1'b1;
                m0_arready = ~grant & s_arready;
                m1_arready = grant & s_arready;
                if (s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m0_rvalid = ~grant & s_rvalid;
                m1_rvalid = grant & s_rvalid;
                s_rready  = grant ? m1_rready : m0_rready;
                // An early rlast still ends the burst; a missing one keeps us here.
                if (s_rvalid & s_rready & s_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            exp_len  <= 8'd0;
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if ((state == ADDR) && s_arready) begin
                exp_len  <= s_arlen;
                beat_cnt <= 8'd0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (beat_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

`ifdef AXI_RD_ARB_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if ((state == IDLE) && (m0_arvalid | m1_arvalid)) begin
            last_grant <= win;
        end
    end
`endif

endmodule
